axil_cmd_mgr: RTL and testbench

AXI-Lite manager that turns single-beat register commands from a simple valid/ready command port into AXI-Lite write (AW+W→B) or read (AR→R) transactions. It returns each transaction's response on a valid/ready response port. It is the initiator end for memory-mapped register blocks (debug bridge, CPU-less bring-up sequencers) and drives any AXI-Lite subordinate directly. Exactly one transaction is outstanding at a time.

---
 rtl/svc_axil_pkg.sv | 17 +
 rtl/axil_cmd_mgr.sv | 121 ++++++++++++
 tb/tb_axil_cmd_mgr.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svc_axil_pkg.sv
// Shared AXI-Lite command manager types: transaction FSM states and response codes.
package svc_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WAIT_B,
    RD_REQ,
    WAIT_R,
    RSP
  } axil_state_e;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_mgr.sv
// AXI-Lite manager: converts single-beat register commands into AXI-Lite write or read
// transactions, one outstanding at a time, and returns the response on a valid/ready port.
module axil_cmd_mgr
  import svc_axil_pkg::*;
#(
  parameter int unsigned AXIL_ADDR_WIDTH = 8,
  parameter int unsigned AXIL_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_wr,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,

  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic                         m_axil_bvalid,
  input  logic [1:0]                   m_axil_bresp,
  output logic                         m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic                         m_axil_rvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  output logic                         m_axil_rready
);

  axil_state_e state_q, state_d;

  logic                         aw_pend_q, w_pend_q;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_q;
  logic                         cmd_hs;
  logic                         aw_done, w_done;

  assign cmd_hs  = cmd_valid && (state_q == IDLE);
  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign aw_done = !aw_pend_q || m_axil_awready;
  assign w_done  = !w_pend_q  || m_axil_wready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid)      state_d = cmd_wr ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_d = WAIT_B;
      WAIT_B:  if (m_axil_bvalid)  state_d = RSP;
      RD_REQ:  if (m_axil_arready) state_d = WAIT_R;
      WAIT_R:  if (m_axil_rvalid)  state_d = RSP;
      RSP:     if (rsp_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state_q == IDLE);
    m_axil_arvalid = (state_q == RD_REQ);
    m_axil_bready  = (state_q == WAIT_B);
    m_axil_rready  = (state_q == WAIT_R);
    rsp_valid      = (state_q == RSP);
    m_axil_awvalid = aw_pend_q;
    m_axil_wvalid  = w_pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else if (cmd_hs) begin
      aw_pend_q <= cmd_wr;
      w_pend_q  <= cmd_wr;
    end else begin
      if (aw_pend_q && m_axil_awready) aw_pend_q <= 1'b0;
      if (w_pend_q  && m_axil_wready)  w_pend_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
    if (m_axil_bvalid && m_axil_bready) begin
      rsp_wr    <= 1'b1;
      rsp_resp  <= m_axil_bresp;
      rsp_rdata <= '0;
    end else if (m_axil_rvalid && m_axil_rready) begin
      rsp_wr    <= 1'b0;
      rsp_resp  <= m_axil_rresp;
      rsp_rdata <= m_axil_rdata;
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;

endmodule

// File: tb/tb_axil_cmd_mgr.sv
// Directed self-checking bench for axil_cmd_mgr with a small configurable AXI-Lite subordinate.
module tb_axil_cmd_mgr;
  import svc_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int pass_cnt = 0;
  int total_cnt = 0;

  // subordinate configuration
  int          aw_delay = 0, w_delay = 0;
  logic        b_block = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  int aw_wait = 0, w_wait = 0;
  logic aw_got = 1'b0, w_got = 1'b0;
  int aw_hi_cnt = 0, w_hi_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;

  axil_cmd_mgr #(.AXIL_ADDR_WIDTH(8), .AXIL_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid;

  always @(posedge clk) begin
    if (!rst_n || !awvalid || awready) aw_wait <= 0; else aw_wait <= aw_wait + 1;
    if (!rst_n || !wvalid  || wready)  w_wait  <= 0; else w_wait  <= w_wait + 1;
    if (awvalid) aw_hi_cnt <= aw_hi_cnt + 1;
    if (wvalid)  w_hi_cnt  <= w_hi_cnt + 1;
    if (awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (wvalid && wready)   w_hs_cnt  <= w_hs_cnt + 1;
    if (bvalid && bready)   b_hs_cnt  <= b_hs_cnt + 1;
  end

  // B channel: respond the cycle after both AW and W have been accepted
  always @(posedge clk) begin
    if (!rst_n) begin
      bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; bresp <= 2'b00;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end else if (!bvalid && !b_block && (aw_got || (awvalid && awready))
                 && (w_got || (wvalid && wready))) begin
      bvalid <= 1'b1; bresp <= b_resp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready)   w_got  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg;
    end
  end

  // Called one step after a rising edge with the DUT idle; returns in cycle T+1.
  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~data; cmd_wstrb = ~strb;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (rsp_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    total_cnt++;
    if (rsp_valid !== 1'b1) $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if ({cmd_ready, rsp_valid} !== 2'b10)
      $display("FAIL after_rsp_hs: cmd_ready,rsp_valid=%b required 10", {cmd_ready, rsp_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total_cnt++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0)
      $display("FAIL reset_valids: %b required 000000",
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: %b required 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_write();
    int lat;
    int aw0, w0, b0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    aw_delay = 0; w_delay = 0; b_resp_cfg = AXIL_RESP_OKAY;
    send_cmd(1'b1, 8'h01, 32'h0000_1000, 4'hF);
    total_cnt++;
    if ({awvalid, wvalid, arvalid, bready, cmd_ready} !== 5'b11000)
      $display("FAIL wr_t1_ctrl: %b required 11000", {awvalid, wvalid, arvalid, bready, cmd_ready});
    else pass_cnt++;
    total_cnt++;
    if ({awaddr, wdata, wstrb} !== {8'h01, 32'h0000_1000, 4'hF})
      $display("FAIL wr_t1_payload: %h %h %h required 01 00001000 f", awaddr, wdata, wstrb);
    else pass_cnt++;
    wait_rsp(lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL wr_latency: %0d required 2", lat); else pass_cnt++;
    total_cnt++;
    if ({rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h0})
      $display("FAIL wr_rsp: wr=%b resp=%b rdata=%h required 1 00 00000000", rsp_wr, rsp_resp, rsp_rdata);
    else pass_cnt++;
    finish_rsp();
    total_cnt++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL wr_beats: aw=%0d w=%0d b=%0d required 1 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_read();
    int lat;
    r_data_cfg = 32'h05F5_E100; r_resp_cfg = AXIL_RESP_OKAY;
    send_cmd(1'b0, 8'h02, 32'hFFFF_FFFF, 4'h0);
    total_cnt++;
    if ({arvalid, awvalid, wvalid, rready, araddr} !== {4'b1000, 8'h02})
      $display("FAIL rd_t1: ar,aw,w,rready=%b araddr=%h required 1000 02",
               {arvalid, awvalid, wvalid, rready}, araddr);
    else pass_cnt++;
    wait_rsp(lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL rd_latency: %0d required 2", lat); else pass_cnt++;
    total_cnt++;
    if ({rsp_wr, rsp_resp, rsp_rdata} !== {1'b0, 2'b00, 32'h05F5_E100})
      $display("FAIL rd_rsp: wr=%b resp=%b rdata=%h required 0 00 05f5e100", rsp_wr, rsp_resp, rsp_rdata);
    else pass_cnt++;
    finish_rsp();
  endtask

  task automatic test_error_resp();
    int lat;
    b_resp_cfg = AXIL_RESP_SLVERR;
    send_cmd(1'b1, 8'h02, 32'h1111_2222, 4'h3);
    wait_rsp(lat);
    total_cnt++;
    if ({rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 32'h0})
      $display("FAIL slverr_rsp: wr=%b resp=%b rdata=%h required 1 10 00000000", rsp_wr, rsp_resp, rsp_rdata);
    else pass_cnt++;
    finish_rsp();
    b_resp_cfg = AXIL_RESP_OKAY;
    r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = AXIL_RESP_DECERR;
    send_cmd(1'b0, 8'hFF, 32'h0, 4'h0);
    wait_rsp(lat);
    total_cnt++;
    if ({rsp_wr, rsp_resp, rsp_rdata} !== {1'b0, 2'b11, 32'hDEAD_BEEF})
      $display("FAIL decerr_rsp: wr=%b resp=%b rdata=%h required 0 11 deadbeef", rsp_wr, rsp_resp, rsp_rdata);
    else pass_cnt++;
    finish_rsp();
    r_resp_cfg = AXIL_RESP_OKAY;
  endtask

  task automatic test_split_handshake(input int awd, input int wd, input int exp_aw_hi,
                                      input int exp_w_hi, input int exp_lat);
    int lat;
    int awh0, wh0, b0;
    awh0 = aw_hi_cnt; wh0 = w_hi_cnt; b0 = b_hs_cnt;
    aw_delay = awd; w_delay = wd;
    send_cmd(1'b1, 8'h40, 32'hCAFE_F00D, 4'h5);
    wait_rsp(lat);
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL split_latency aw%0d/w%0d: %0d required %0d", awd, wd, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if ((aw_hi_cnt - awh0) !== exp_aw_hi || (w_hi_cnt - wh0) !== exp_w_hi || (b_hs_cnt - b0) !== 1)
      $display("FAIL split_beats aw%0d/w%0d: awvalid_cycles=%0d wvalid_cycles=%0d b=%0d required %0d %0d 1",
               awd, wd, aw_hi_cnt - awh0, w_hi_cnt - wh0, b_hs_cnt - b0, exp_aw_hi, exp_w_hi);
    else pass_cnt++;
    finish_rsp();
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_rsp_backpressure();
    int lat;
    r_data_cfg = 32'hA5A5_5A5A; r_resp_cfg = AXIL_RESP_OKAY;
    send_cmd(1'b0, 8'h33, 32'h0, 4'h0);
    wait_rsp(lat);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h77;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({rsp_valid, cmd_ready, rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'hA5A5_5A5A})
        $display("FAIL backpressure_hold%0d: valid=%b cmd_ready=%b wr=%b resp=%b rdata=%h required 1 0 0 00 a5a55a5a",
                 i, rsp_valid, cmd_ready, rsp_wr, rsp_resp, rsp_rdata);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    b_block = 1'b1;
    send_cmd(1'b1, 8'h20, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (bready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (bready !== 1'b1) $display("FAIL reach_wait_b: bready=%b required 1", bready);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_block = 1'b0;
    total_cnt++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0000001)
      $display("FAIL midreset_state: %b required 0000001",
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    else pass_cnt++;
    r_data_cfg = 32'h1234_5678;
    send_cmd(1'b0, 8'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    total_cnt++;
    if ({lat, rsp_wr, rsp_resp, rsp_rdata} !== {32'd2, 1'b0, 2'b00, 32'h1234_5678})
      $display("FAIL post_reset_read: lat=%0d wr=%b resp=%b rdata=%h required 2 0 00 12345678",
               lat, rsp_wr, rsp_resp, rsp_rdata);
    else pass_cnt++;
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error_resp();
    // AW held off 3 cycles while W goes immediately, then the mirror case
    test_split_handshake(3, 0, 4, 1, 5);
    test_split_handshake(0, 2, 1, 3, 4);
    test_rsp_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
